// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
// Watches an asynchronous checkpoint bus and tracks NUM_CH independent
// expected-value sequences in parallel under one global RUN-cycle timeout.
// Each channel advances one entry per cycle when the synchronised bus equals
// its next expected value. The run ends with a sticky pass verdict once every
// channel is complete, or with a sticky fail verdict on timeout.
//
// Ports:
//   clock, resetb        clock (rising edge), async active-low reset
//   cfg_we/cfg_ch/cfg_idx/cfg_data   expected-entry write (ignored while busy)
//   cfg_len_we/cfg_len   channel length write, clamped to DEPTH
//   timeout_limit        RUN-cycle budget, 0 disables the timeout
//   start, abort         one-cycle control pulses
//   checkbits            asynchronous checkpoint bus
//   busy/done/pass/fail  run status and sticky verdict
//   ch_done, ch_ptr      per-channel completion and next-entry index
//   hit_pulse            one-cycle pulse per matched entry
//   cycle_cnt            RUN cycles elapsed (saturating)
module checkpoint_seq_monitor #(
  parameter int unsigned W      = 16,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TO_W   = 32,
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW    = IW + 1
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_ch,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [W-1:0]         cfg_data,
  input  logic                 cfg_len_we,
  input  logic [LW-1:0]        cfg_len,
  input  logic [TO_W-1:0]      timeout_limit,
  input  logic                 start,
  input  logic                 abort,
  input  logic [W-1:0]         checkbits,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH*LW-1:0] ch_ptr,
  output logic [NUM_CH-1:0]    hit_pulse,
  output logic [TO_W-1:0]      cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        sync1_q, sync2_q;
  logic [W-1:0]        exp_mem [NUM_CH][DEPTH];
  logic [LW-1:0]       len_q   [NUM_CH];
  logic [LW-1:0]       ptr_q   [NUM_CH];
  logic [LW-1:0]       ptr_d   [NUM_CH];
  logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
  logic [NUM_CH-1:0]   hit_q, hit_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  logic                cfg_ch_ok_c;
  logic                cfg_idx_ok_c;
  logic [LW-1:0]       cfg_len_clamp_c;
  logic                timeout_c;

  // Configuration qualifiers: out-of-range channel/index writes are dropped.
  assign cfg_ch_ok_c     = (32'(cfg_ch) < NUM_CH) && !busy_q;
  assign cfg_idx_ok_c    = (32'(cfg_idx) < DEPTH);
  assign cfg_len_clamp_c = (32'(cfg_len) > DEPTH) ? LW'(DEPTH) : cfg_len;

  // Timeout fires on the edge where the budget's last cycle is being spent.
  assign timeout_c = (timeout_limit != '0) &&
                     (cnt_q == TO_W'(timeout_limit - TO_W'(1)));

  // Two-flop synchroniser for the asynchronous checkpoint bus.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= checkbits;
      sync2_q <= sync1_q;
    end
  end

  // Expected-value storage; contents survive reset by design.
  always_ff @(posedge clock) begin
    if (cfg_we && cfg_ch_ok_c && cfg_idx_ok_c) begin
      exp_mem[cfg_ch][cfg_idx] <= cfg_data;
    end
  end

  // Per-channel sequence lengths.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int c = 0; c < NUM_CH; c++) begin
        len_q[c] <= '0;
      end
    end else if (cfg_len_we && cfg_ch_ok_c) begin
      len_q[cfg_ch] <= cfg_len_clamp_c;
    end
  end

  // State and run-tracking registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      ch_done_q <= '0;
      hit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      cnt_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ptr_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_done_q <= ch_done_d;
      hit_q     <= hit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      cnt_q     <= cnt_d;
      for (int c = 0; c < NUM_CH; c++) begin
        ptr_q[c] <= ptr_d[c];
      end
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d   = state_q;
    ch_done_d = ch_done_q;
    hit_d     = '0;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    cnt_d     = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      ptr_d[c] = ptr_q[c];
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          for (int c = 0; c < NUM_CH; c++) begin
            ptr_d[c]     = '0;
            ch_done_d[c] = (len_q[c] == '0);
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          // Cancel without a verdict; pointers stay for inspection.
          state_d = S_IDLE;
        end else begin
          // Level match: at most one entry per channel per cycle.
          for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_done_q[c] && (sync2_q == exp_mem[c][IW'(ptr_q[c])])) begin
              ptr_d[c] = LW'(ptr_q[c] + LW'(1));
              hit_d[c] = 1'b1;
              if (ptr_d[c] == len_q[c]) begin
                ch_done_d[c] = 1'b1;
              end
            end
          end
          // Completion on this edge wins over a coincident timeout.
          if (&ch_done_d) begin
            state_d = S_PASS;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (timeout_c) begin
            state_d = S_FAIL;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = TO_W'(cnt_q + TO_W'(1));
          end
        end
      end

      S_PASS, S_FAIL: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign ch_done   = ch_done_q;
  assign hit_pulse = hit_q;
  assign cycle_cnt = cnt_q;

  // Flatten channel pointers, channel 0 in the LSBs.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ptr
    assign ch_ptr[g*LW +: LW] = ptr_q[g];
  end

endmodule
